muldiv_sequencer: RTL

//  Multi-cycle sequencer for the RV32M divide/remainder group (DIV, DIVU, REM, REMU).

---
 rtl/muldiv_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle sequencer for the RV32M divide/remainder group (DIV, DIVU, REM,
// REMU). It sits in EX beside the single-cycle ALU and runs a radix-2
// restoring division, one quotient bit per clock. The multiply group
// (funct3[2]=0) stays in the ALU and is ignored here.
//
// Handshake: an op is accepted when i_start & i_funct3[2] & ~i_flush and the
// FSM is IDLE. o_stall is high in the accept cycle and in every CALC cycle,
// so the pipeline keeps re-presenting the same op (START is ignored while
// busy). o_done is a one-cycle pulse with o_stall low, which is the cycle in
// which EX captures o_result and advances. o_result holds until the next
// o_done or reset.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      EX holds an M-extension op this cycle
//   i_funct3     100 DIV, 101 DIVU, 110 REM, 111 REMU; bit 2 clear -> ignored
//   i_operand1   dividend (rs1)
//   i_operand2   divisor (rs2)
//   i_flush      branch/jump flush of EX; aborts the running operation
//   o_stall      hold PC, IF/ID and ID/EX this cycle
//   o_done       one-cycle pulse, o_result valid
//   o_result     quotient (DIV/DIVU) or remainder (REM/REMU)
//   o_state      FSM state for debug/checkers (0 IDLE, 1 CALC, 2 DONE)
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_operand1,
    input  logic [XLEN-1:0] i_operand2,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic [1:0]      o_state
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] L_ONE  = XLEN'(1);
    localparam logic [XLEN-1:0] L_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] L_ONES = {XLEN{1'b1}};
    localparam logic [CW-1:0]   L_LAST = CW'(XLEN-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_is_rem;
    logic [XLEN-1:0] r_result;

    // ------------------------------------------------------------------
    // Accept-time decode
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_signed;
    logic            w_is_rem;
    logic            w_neg1;
    logic            w_neg2;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_result;

    assign w_accept = i_start & i_funct3[2] & ~i_flush & (r_state == S_IDLE);
    assign w_signed = ~i_funct3[0];
    assign w_is_rem = i_funct3[1];

    assign w_neg1 = w_signed & i_operand1[XLEN-1];
    assign w_neg2 = w_signed & i_operand2[XLEN-1];
    assign w_abs1 = w_neg1 ? (~i_operand1 + L_ONE) : i_operand1;
    assign w_abs2 = w_neg2 ? (~i_operand2 + L_ONE) : i_operand2;

    // Divide-by-zero and signed overflow are answered at accept without
    // iterating; the results are the RISC-V architected values.
    assign w_div_zero = (i_operand2 == '0);
    assign w_ovf      = w_signed & (i_operand1 == L_MIN) & (i_operand2 == L_ONES);
    assign w_special  = w_div_zero | w_ovf;

    always_comb begin
        w_special_result = '0;
        if (w_div_zero) begin
            w_special_result = w_is_rem ? i_operand1 : L_ONES;
        end else if (w_ovf) begin
            w_special_result = w_is_rem ? '0 : L_MIN;
        end
    end

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    // The shifted partial remainder needs XLEN+1 bits: before the compare it
    // can reach 2*divisor-1. After a successful subtract it is below the
    // divisor again, so the XLEN-bit difference is exact.
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_sub;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic            w_last;
    logic [XLEN-1:0] w_final_result;

    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_div});
    assign w_sub    = w_rem_sh[XLEN-1:0] - r_div;
    assign w_rem_nx = w_ge ? w_sub : w_rem_sh[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};
    assign w_last   = (r_count == L_LAST);

    always_comb begin
        w_final_result = '0;
        if (r_is_rem) begin
            w_final_result = r_neg_r ? (~w_rem_nx + L_ONE) : w_rem_nx;
        end else begin
            w_final_result = r_neg_q ? (~w_quo_nx + L_ONE) : w_quo_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                // A flush abandons the op silently; no DONE pulse.
                if (i_flush) begin
                    w_next_state = S_IDLE;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_stall  = w_accept | (r_state == S_CALC);
        o_done   = (r_state == S_DONE);
        o_result = r_result;
        o_state  = r_state;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_count  <= '0;
            r_rem    <= '0;
            r_quo    <= w_abs1;
            r_div    <= w_abs2;
            r_neg_q  <= w_neg1 ^ w_neg2;
            r_neg_r  <= w_neg1;
            r_is_rem <= w_is_rem;
            if (w_special) begin
                r_result <= w_special_result;
            end
        end else if ((r_state == S_CALC) && !i_flush) begin
            r_rem   <= w_rem_nx;
            r_quo   <= w_quo_nx;
            r_count <= r_count + CW'(1);
            if (w_last) begin
                r_result <= w_final_result;
            end
        end
    end

endmodule
